// File: rtl/ascon_bdi_packer.sv
// Packs a typed host byte stream into CCW-bit Ascon bdi words (byte 0 in lane 0, unused lanes zero).
// Latency: a word is presented the cycle after its closing byte; a byte may overlap the departing word.
// Backpressure: s_ready=1 while filling, s_ready=bdi_ready while a word is held.
// Optional: define ASCON_PACKER_ERR_EN for sticky protocol error detection and dropping of offending bytes.
// Type encoding: D_NULL=0, D_NONCE=1, D_AD=2, D_MSG=3, D_TAG=4, D_HASH=5.
module ascon_bdi_packer #(
  parameter int CCW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [3:0]           s_type,
  input  logic                 s_last,
  input  logic                 s_final,
  output logic [CCW-1:0]       bdi,
  output logic [CCW/8-1:0]     bdi_valid,
  input  logic                 bdi_ready,
  output logic [3:0]           bdi_type,
  output logic                 bdi_eot,
  output logic                 bdi_eoi,
  output logic                 idle,
  output logic                 err
);

  localparam int BPW = CCW / 8;
  localparam logic [3:0] D_NULL = 4'd0;
  localparam logic [3:0] D_HASH = 4'd5;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CCW-1:0]   buf_q, buf_d;
  logic [3:0]       typ_q, typ_d;
  logic [CCW-1:0]   bdi_q, bdi_d;
  logic [BPW-1:0]   bdi_valid_q, bdi_valid_d;
  logic [3:0]       bdi_type_q, bdi_type_d;
  logic             bdi_eot_q, bdi_eot_d;
  logic             bdi_eoi_q, bdi_eoi_d;
  logic             idle_q, idle_d;
`ifdef ASCON_PACKER_ERR_EN
  logic             err_q, err_d;
  logic             done_q, done_d;
`endif

  logic             acc;
  logic             leaving;
  logic             drop;
  logic [3:0]       ncnt;
  logic [CCW-1:0]   wbuf;
  logic [3:0]       wtype;

  // Only the input handshake looks at bdi_ready combinationally.
  assign s_ready = (state_q == FILL) ? 1'b1 : bdi_ready;

  // Next-state: retire the held word, then place the accepted byte (the assembly buffer is empty while holding).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    typ_d       = typ_q;
    bdi_d       = bdi_q;
    bdi_valid_d = bdi_valid_q;
    bdi_type_d  = bdi_type_q;
    bdi_eot_d   = bdi_eot_q;
    bdi_eoi_d   = bdi_eoi_q;
    acc         = s_valid && s_ready;
    leaving     = (state_q == HOLD) && bdi_ready;
    ncnt        = cnt_q + 4'd1;
    wbuf        = buf_q | ({{(CCW-8){1'b0}}, s_data} << (8 * cnt_q));
    wtype       = (cnt_q == 4'd0) ? s_type : typ_q;
    drop        = 1'b0;
`ifdef ASCON_PACKER_ERR_EN
    err_d       = err_q;
    done_d      = done_q;
    if (acc && (((cnt_q != 4'd0) && (s_type != typ_q)) ||
                (s_type == D_NULL) || (s_type == D_HASH) || done_q)) begin
      drop  = 1'b1;
      err_d = 1'b1;
    end
`endif
    if (leaving) begin
      state_d     = FILL;
      bdi_d       = '0;
      bdi_valid_d = '0;
      bdi_type_d  = D_NULL;
      bdi_eot_d   = 1'b0;
      bdi_eoi_d   = 1'b0;
    end
    if (acc && !drop) begin
      if ((ncnt == 4'(BPW)) || s_last) begin
        state_d    = HOLD;
        bdi_d      = wbuf;
        bdi_type_d = wtype;
        bdi_eot_d  = s_last;
        bdi_eoi_d  = s_last && s_final;
        for (int k = 0; k < BPW; k++) begin
          bdi_valid_d[k] = (ncnt > 4'(k));
        end
        buf_d = '0;
        cnt_d = 4'd0;
        typ_d = D_NULL;
`ifdef ASCON_PACKER_ERR_EN
        done_d = done_q || (s_last && s_final);
`endif
      end else begin
        buf_d = wbuf;
        cnt_d = ncnt;
        typ_d = wtype;
      end
    end
    idle_d = (state_d == FILL) && (cnt_d == 4'd0);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= 4'd0;
      buf_q       <= '0;
      typ_q       <= D_NULL;
      bdi_q       <= '0;
      bdi_valid_q <= '0;
      bdi_type_q  <= D_NULL;
      bdi_eot_q   <= 1'b0;
      bdi_eoi_q   <= 1'b0;
      idle_q      <= 1'b1;
`ifdef ASCON_PACKER_ERR_EN
      err_q       <= 1'b0;
      done_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      typ_q       <= typ_d;
      bdi_q       <= bdi_d;
      bdi_valid_q <= bdi_valid_d;
      bdi_type_q  <= bdi_type_d;
      bdi_eot_q   <= bdi_eot_d;
      bdi_eoi_q   <= bdi_eoi_d;
      idle_q      <= idle_d;
`ifdef ASCON_PACKER_ERR_EN
      err_q       <= err_d;
      done_q      <= done_d;
`endif
    end
  end

  assign bdi       = bdi_q;
  assign bdi_valid = bdi_valid_q;
  assign bdi_type  = bdi_type_q;
  assign bdi_eot   = bdi_eot_q;
  assign bdi_eoi   = bdi_eoi_q;
  assign idle      = idle_q;
`ifdef ASCON_PACKER_ERR_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
